// File: rtl/frame_source_writer.sv
// Draw-source bus consumer: walks sources 0..NUM_SOURCES-1 and writes their opaque, in-range
// pixels into the frame buffer. Optional start timeout via `FRAME_WRITER_TIMEOUT_EN.
module frame_source_writer #(
    parameter int NUM_SOURCES       = 4,
    parameter int SOURCE_SEL_ADDRW  = 2,
    parameter int COLOR_DEPTH       = 8,
    parameter int DRAW_WIDTH        = 160,
    parameter int DRAW_WIDTH_ADDRW  = 8,
    parameter int DRAW_HEIGHT       = 120,
    parameter int DRAW_HEIGHT_ADDRW = 7,
    parameter int MEM_ADDRW         = 15,
    parameter int START_TIMEOUT     = 16
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         frame_start,
    output logic                         busy,
    output logic                         frame_done,
    output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
    output logic                         write_awaited,
    input  logic                         write_active,
    input  logic [COLOR_DEPTH-1:0]       write_color_data,
    input  logic                         write_transparent,
    input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
    input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
    output logic                         mem_we,
    output logic [MEM_ADDRW-1:0]         mem_addr,
    output logic [COLOR_DEPTH-1:0]       mem_wdata,
    output logic                         source_timeout
);

    typedef enum logic [2:0] {IDLE, SELECT, WAIT_START, STREAM, NEXT, DONE} state_t;

    localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_SEL = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);
    // One extra bit keeps the limit representable even when it equals 2**ADDRW
    localparam logic [DRAW_WIDTH_ADDRW:0]  X_LIM = (DRAW_WIDTH_ADDRW+1)'(DRAW_WIDTH);
    localparam logic [DRAW_HEIGHT_ADDRW:0] Y_LIM = (DRAW_HEIGHT_ADDRW+1)'(DRAW_HEIGHT);

    state_t               state;
    logic                 in_range;
    logic                 px_we;
    logic [MEM_ADDRW-1:0] px_addr;

    assign in_range = ({1'b0, write_x_addr} < X_LIM) && ({1'b0, write_y_addr} < Y_LIM);
    assign px_we    = write_active && !write_transparent && in_range;
    assign px_addr  = MEM_ADDRW'(write_y_addr) * MEM_ADDRW'(DRAW_WIDTH) + MEM_ADDRW'(write_x_addr);

`ifdef FRAME_WRITER_TIMEOUT_EN
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign source_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state            <= IDLE;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            write_awaited    <= 1'b0;
            write_source_sel <= '0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
`ifdef FRAME_WRITER_TIMEOUT_EN
            tmo_cnt          <= '0;
            source_timeout   <= 1'b0;
`endif
        end else begin
            mem_we        <= 1'b0;
            frame_done    <= 1'b0;
            write_awaited <= 1'b0;
            unique case (state)
                IDLE: if (frame_start) begin
                    state            <= SELECT;
                    write_source_sel <= '0;
                    busy             <= 1'b1;
                    write_awaited    <= 1'b1;
                end
                SELECT: begin
                    state <= WAIT_START;
`ifdef FRAME_WRITER_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT_START: begin
                    if (write_active) state <= STREAM;
`ifdef FRAME_WRITER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        state          <= NEXT;
                        source_timeout <= 1'b1;
                    end else tmo_cnt <= tmo_cnt + 1'b1;
`endif
                end
                STREAM: if (!write_active) state <= NEXT;
                NEXT: begin
                    if (write_source_sel == LAST_SEL) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        write_source_sel <= write_source_sel + 1'b1;
                        state            <= SELECT;
                        write_awaited    <= 1'b1;
                    end
                end
                DONE: begin
                    state            <= IDLE;
                    busy             <= 1'b0;
                    write_source_sel <= '0;
                end
                default: state <= IDLE;
            endcase
            // Pixels are taken on the first active cycle too, so no pixel is lost on start
            if ((state == WAIT_START || state == STREAM) && px_we) begin
                mem_we    <= 1'b1;
                mem_addr  <= px_addr;
                mem_wdata <= write_color_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_source_writer.sv
// Directed bench for frame_source_writer on a 4x2 frame with two behavioural sources.
module tb_frame_source_writer;

    logic       clk = 1'b0;
    logic       resetN;
    logic       frame_start;
    logic       busy, frame_done, write_awaited, mem_we, source_timeout;
    logic       write_source_sel;
    logic       write_active, write_transparent;
    logic [7:0] write_color_data;
    logic [2:0] write_x_addr;
    logic [1:0] write_y_addr;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;

    logic [7:0] ram [0:7];
    int         we_cnt = 0, done_cnt = 0;
    int         total = 0, bad = 0;
    int         we0, done0;

    frame_source_writer #(
        .NUM_SOURCES(2), .SOURCE_SEL_ADDRW(1), .COLOR_DEPTH(8),
        .DRAW_WIDTH(4), .DRAW_WIDTH_ADDRW(3), .DRAW_HEIGHT(2), .DRAW_HEIGHT_ADDRW(2),
        .MEM_ADDRW(3), .START_TIMEOUT(16)
    ) dut (
        .clk(clk), .resetN(resetN), .frame_start(frame_start), .busy(busy),
        .frame_done(frame_done), .write_source_sel(write_source_sel),
        .write_awaited(write_awaited), .write_active(write_active),
        .write_color_data(write_color_data), .write_transparent(write_transparent),
        .write_x_addr(write_x_addr), .write_y_addr(write_y_addr), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .source_timeout(source_timeout)
    );

    always #5 clk = ~clk;

    // Frame-buffer model plus write/done counters
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        frame_start = 1'b1; step(); frame_start = 1'b0;
    endtask

    // Waits for the request to source s, then lets the DUT reach WAIT_START
    task automatic await_src(input string tag, input logic s);
        int seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (write_awaited) begin seen = 1; break; end
            step();
        end
        chk({tag, "_awaited"}, seen, 1);
        chk({tag, "_sel"}, write_source_sel, s);
        step();
    endtask

    task automatic px(input int x, input int y, input logic [7:0] c, input logic t);
        write_active = 1'b1; write_x_addr = 3'(x); write_y_addr = 2'(y);
        write_color_data = c; write_transparent = t;
        step();
    endtask

    task automatic end_stream();
        write_active = 1'b0; write_transparent = 1'b0; step();
    endtask

    task automatic wait_done(input string tag);
        int seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (frame_done) begin seen = 1; break; end
            step();
        end
        chk({tag, "_done"}, seen, 1);
        step();
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ram[i] = 8'h00;
        resetN = 1'b0; frame_start = 1'b0; write_active = 1'b0; write_transparent = 1'b0;
        write_color_data = 8'h00; write_x_addr = 3'd0; write_y_addr = 2'd0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_awaited", write_awaited, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_sel", write_source_sel, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_tmo", source_timeout, 0);
        resetN = 1'b1; step();

        // 1: src0 fills the frame with 49, src1 sends only a transparent pixel
        we0 = we_cnt; done0 = done_cnt;
        start_frame();
        chk("t1_busy", busy, 1);
        await_src("t1_s0", 1'b0);
        px(0, 0, 8'h49, 1'b0);
        chk("t1_lat_we", mem_we, 1);
        chk("t1_lat_addr", mem_addr, 0);
        chk("t1_lat_data", mem_wdata, 8'h49);
        for (int i = 1; i < 8; i++) px(i % 4, i / 4, 8'h49, 1'b0);
        end_stream();
        await_src("t1_s1", 1'b1);
        px(0, 0, 8'hFF, 1'b1);
        end_stream();
        wait_done("t1");
        chk("t1_we_cnt", we_cnt - we0, 8);
        chk("t1_done_cnt", done_cnt - done0, 1);
        for (int i = 0; i < 8; i++) chk("t1_ram", ram[i], 8'h49);

        // 2: src1 overwrites (1,1), transparent (2,1) leaves the old pixel
        start_frame();
        await_src("t2_s0", 1'b0);
        px(1, 1, 8'h11, 1'b0);
        end_stream();
        await_src("t2_s1", 1'b1);
        px(1, 1, 8'hE0, 1'b0);
        px(2, 1, 8'h77, 1'b1);
        end_stream();
        wait_done("t2");
        chk("t2_ram5", ram[5], 8'hE0);
        chk("t2_ram6", ram[6], 8'h49);

        // 3+4: out-of-range pixels dropped; frame_start mid-frame ignored
        we0 = we_cnt; done0 = done_cnt;
        start_frame();
        await_src("t3_s0", 1'b0);
        px(4, 0, 8'h11, 1'b0);
        chk("t3_x_oor_we", mem_we, 0);
        frame_start = 1'b1;
        px(0, 2, 8'h22, 1'b0);
        frame_start = 1'b0;
        chk("t3_y_oor_we", mem_we, 0);
        px(3, 1, 8'h33, 1'b0);
        chk("t3_ok_we", mem_we, 1);
        chk("t3_ok_addr", mem_addr, 7);
        end_stream();
        await_src("t3_s1", 1'b1);
        px(0, 0, 8'h00, 1'b1);
        end_stream();
        wait_done("t3");
        repeat (5) step();
        chk("t3_we_cnt", we_cnt - we0, 1);
        chk("t3_ram7", ram[7], 8'h33);
        chk("t3_ram4", ram[4], 8'h49);
        chk("t3_ram0", ram[0], 8'h49);
        chk("t4_one_done", done_cnt - done0, 1);
        chk("t4_idle_busy", busy, 0);

        // 5: reset during src0 stream, then a clean frame
        start_frame();
        await_src("t5_s0", 1'b0);
        px(0, 0, 8'h55, 1'b0);
        px(1, 0, 8'h55, 1'b0);
        resetN = 1'b0;
        px(2, 0, 8'h55, 1'b0);
        chk("t5_rst_we", mem_we, 0);
        chk("t5_rst_awaited", write_awaited, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_sel", write_source_sel, 0);
        resetN = 1'b1;
        end_stream();
        chk("t5_ram2", ram[2], 8'h49);
        start_frame();
        await_src("t5b_s0", 1'b0);
        px(3, 0, 8'h66, 1'b0);
        end_stream();
        await_src("t5b_s1", 1'b1);
        px(0, 0, 8'h00, 1'b1);
        end_stream();
        wait_done("t5b");
        chk("t5b_ram3", ram[3], 8'h66);

        // 6: src1 never starts
        done0 = done_cnt;
        start_frame();
        await_src("t6_s0", 1'b0);
        px(0, 1, 8'h99, 1'b0);
        end_stream();
        await_src("t6_s1", 1'b1);
        repeat (40) step();
`ifdef FRAME_WRITER_TIMEOUT_EN
        chk("t6_timeout", source_timeout, 1);
        chk("t6_done_cnt", done_cnt - done0, 1);
        chk("t6_busy", busy, 0);
`else
        chk("t6_timeout", source_timeout, 0);
        chk("t6_done_cnt", done_cnt - done0, 0);
        chk("t6_busy", busy, 1);
`endif
        chk("t6_ram4", ram[4], 8'h99);
        resetN = 1'b0; step();
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_tmo", source_timeout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
